inst_buffer: RTL and testbench
==============================

// Module: inst_buffer
// PURPOSE
// Circular instruction queue between fetch and the dual-issue decode stage. Fetch pushes up to
// 2 instructions and their PCs per cycle. Decode reads the two oldest entries each cycle.
// Decode reports single or dual issue, and the buffer pops 1 or 2 entries to match.
// A flush (branch redirect or exception) empties the queue in one cycle.
// PARAMETERS
// DEPTH   16  number of entries; power of two, minimum 4
// PTR_W   4   log2(DEPTH); pointer width (count is PTR_W+1 bits)
// PORTS
// clk            in   1   clock; all state changes on the rising edge
// rst            in   1   synchronous reset, active-low (rst==0 resets on the clk edge)
// flush_i        in   1   discard all entries this cycle
// stall_i        in   1   back-end stall; suppresses pop
// fetch_we1_i    in   1   push slot 1 valid
// fetch_we2_i    in   1   push slot 2 valid; ignored unless fetch_we1_i=1
// fetch_inst1_i  in   32  instruction, slot 1 (older)
// fetch_inst2_i  in   32  instruction, slot 2
// fetch_addr1_i  in   32  PC, slot 1
// fetch_addr2_i  in   32  PC, slot 2
// full_o         out  1   fewer than 2 free entries; fetch must hold
// issue_i        in   1   decode choice: `DualIssue or `SingleIssue
// issued_i       in   1   decode consumed the head this cycle
// issue_en_o     out  1   head entry valid (>=1 entry stored)
// inst2_valid_o  out  1   second entry valid (>=2 entries stored)
// inst1_o        out  32  head instruction
// inst2_o        out  32  head+1 instruction
// inst1_addr_o   out  32  head PC
// inst2_addr_o   out  32  head+1 PC
// BEHAVIOUR
// - State: array of DEPTH {inst,addr} entries, head ptr, tail ptr, count. Pointers wrap modulo DEPTH.
// - Reset (rst==0): head=tail=count=0 and array cleared. Outputs are then issue_en_o=0,
//   inst2_valid_o=0, full_o=0, all data outputs 0.
// - Read side is combinational from registered state: zero latency from head to outputs.
//   - inst1_o/inst1_addr_o = entry[head] when count>=1, else 0.
//   - inst2_o/inst2_addr_o = entry[head+1] when count>=2, else 0 (0 decodes as NOP).
// - push_n = fetch_we1_i + (fetch_we1_i & fetch_we2_i).
//   - A push is accepted only when full_o=0 and flush_i=0.
//   - Slot 1 is written at tail, slot 2 at tail+1 (wrap). Then tail += push_n.
// - req_n = 0 when issued_i=0, stall_i=1 or flush_i=1; 2 when issue_i==`DualIssue; otherwise 1.
//   - pop_n = min(req_n, count). A dual request with count=1 pops exactly 1; never underflow.
//   - head += pop_n.
// - count_next = count + accepted push_n - pop_n. Push and pop in the same cycle are both honoured.
// - full_o = (DEPTH - count) < 2. It is evaluated before this cycle's pop (conservative), so overflow is impossible.
// - flush_i=1: head=tail=count=0 next cycle. Same-cycle push and pop are discarded; flush wins all.
// - Reset mid-operation behaves exactly like flush, and also clears the array.
// - Issue is never reordered: slot 1 is always older than slot 2, on both the push and read sides.
// TESTING
// 1 Reset, then idle 3 cycles -> issue_en_o=0, inst2_valid_o=0, full_o=0, all data outputs 0.
// 2 Dual push (0x24010001@0xBFC00000, 0x24020002@0xBFC00004), then issued_i=1 with
//   `DualIssue -> both appear at the outputs the next cycle; one cycle later count=0 and issue_en_o=0.
// 3 Push 3 entries, then `DualIssue -> pop 2; next cycle inst1_addr_o is the 3rd PC and inst2_valid_o=0.
//   Another `DualIssue with count=1 -> pop 1 and count=0.
// 4 Fill to 14 entries -> full_o=0. Fill to 15 -> full_o=1, and a push request leaves tail unchanged.
//   Pop 1 -> full_o=0.
// 5 Wrap test: cycle 40 pushes through index 15->0 while popping.
//   -> FIFO order of PCs is preserved across the wrap point.
// 6 flush_i together with push, issued_i and `DualIssue at count=6 -> next cycle count=0, issue_en_o=0.
//   Separately, stall_i=1 with issued_i=1 -> count unchanged.

Source files
------------

// File: rtl/inst_buffer.sv
// Circular fetch-to-decode instruction queue: up to 2 pushes and 2 pops per cycle, flush empties it.
// Latency: head entries are visible combinationally from registered state; a push is readable the next cycle.
// Backpressure: full_o (fewer than 2 free slots, judged before this cycle's pop) holds fetch; pops never underflow.
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        fetch_we1_i,
    input  logic        fetch_we2_i,
    input  logic [31:0] fetch_inst1_i,
    input  logic [31:0] fetch_inst2_i,
    input  logic [31:0] fetch_addr1_i,
    input  logic [31:0] fetch_addr2_i,
    output logic        full_o,
    input  logic        issue_i,
    input  logic        issued_i,
    output logic        issue_en_o,
    output logic        inst2_valid_o,
    output logic [31:0] inst1_o,
    output logic [31:0] inst2_o,
    output logic [31:0] inst1_addr_o,
    output logic [31:0] inst2_addr_o
);

    localparam logic DUAL_ISSUE = 1'b1;

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      addr_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic [1:0]       push_n;
    logic [1:0]       req_n;
    logic [1:0]       pop_n;

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Full looks at the pre-pop count so a same-cycle pop can never be relied on to make room.
    assign full_o        = (count >= (PTR_W+1)'(DEPTH - 1));
    assign issue_en_o    = (count != '0);
    assign inst2_valid_o = (count >= (PTR_W+1)'(2));
    assign inst1_o       = issue_en_o    ? inst_mem[head]    : '0;
    assign inst1_addr_o  = issue_en_o    ? addr_mem[head]    : '0;
    assign inst2_o       = inst2_valid_o ? inst_mem[head_p1] : '0;
    assign inst2_addr_o  = inst2_valid_o ? addr_mem[head_p1] : '0;

    always_comb begin
        push_n = 2'd0;
        req_n  = 2'd0;
        if (!full_o && !flush_i) begin
            push_n = {1'b0, fetch_we1_i} + {1'b0, fetch_we1_i & fetch_we2_i};
        end
        if (issued_i && !stall_i && !flush_i) begin
            req_n = (issue_i == DUAL_ISSUE) ? 2'd2 : 2'd1;
        end
        // A request larger than count only happens when count <= 1, so its low bits suffice.
        pop_n      = ((PTR_W+1)'(req_n) > count) ? count[1:0] : req_n;
        count_next = count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                addr_mem[i] <= '0;
            end
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_n != 2'd0) begin
                inst_mem[tail] <= fetch_inst1_i;
                addr_mem[tail] <= fetch_addr1_i;
            end
            if (push_n == 2'd2) begin
                inst_mem[tail_p1] <= fetch_inst2_i;
                addr_mem[tail_p1] <= fetch_addr2_i;
            end
            tail  <= tail + PTR_W'(push_n);
            head  <= head + PTR_W'(pop_n);
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: a queue model tracks stored {inst,addr} pairs and
// every cycle the DUT head outputs are compared against the model's oldest entries.
module tb_inst_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, stall_i, fetch_we1_i, fetch_we2_i, issue_i, issued_i;
    logic [31:0] fetch_inst1_i, fetch_inst2_i, fetch_addr1_i, fetch_addr2_i;
    logic        full_o, issue_en_o, inst2_valid_o;
    logic [31:0] inst1_o, inst2_o, inst1_addr_o, inst2_addr_o;

    always #5 clk = ~clk;

    inst_buffer #(.DEPTH(16), .PTR_W(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
        .fetch_we1_i(fetch_we1_i), .fetch_we2_i(fetch_we2_i),
        .fetch_inst1_i(fetch_inst1_i), .fetch_inst2_i(fetch_inst2_i),
        .fetch_addr1_i(fetch_addr1_i), .fetch_addr2_i(fetch_addr2_i),
        .full_o(full_o), .issue_i(issue_i), .issued_i(issued_i),
        .issue_en_o(issue_en_o), .inst2_valid_o(inst2_valid_o),
        .inst1_o(inst1_o), .inst2_o(inst2_o),
        .inst1_addr_o(inst1_addr_o), .inst2_addr_o(inst2_addr_o)
    );

    logic [63:0] mq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] seq     = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = mq.size();
        chk("issue_en",    {31'b0, issue_en_o},    {31'b0, (n >= 1)});
        chk("inst2_valid", {31'b0, inst2_valid_o}, {31'b0, (n >= 2)});
        chk("full",        {31'b0, full_o},        {31'b0, ((16 - n) < 2)});
        chk("inst1",      inst1_o,      (n >= 1) ? mq[0][63:32] : 32'd0);
        chk("inst1_addr", inst1_addr_o, (n >= 1) ? mq[0][31:0]  : 32'd0);
        chk("inst2",      inst2_o,      (n >= 2) ? mq[1][63:32] : 32'd0);
        chk("inst2_addr", inst2_addr_o, (n >= 2) ? mq[1][31:0]  : 32'd0);
    endtask

    // Drive one cycle, check outputs mid-cycle, update the model to match the coming edge.
    task automatic step(input logic we1, input logic we2,
                        input logic [31:0] i1, input logic [31:0] a1,
                        input logic [31:0] i2, input logic [31:0] a2,
                        input logic issued, input logic dual, input logic stall, input logic flush);
        int  req;
        int  popn;
        bit  full_m;
        fetch_we1_i = we1;  fetch_we2_i = we2;
        fetch_inst1_i = i1; fetch_addr1_i = a1;
        fetch_inst2_i = i2; fetch_addr2_i = a2;
        issued_i = issued;  issue_i = dual;
        stall_i = stall;    flush_i = flush;
        @(negedge clk);
        check_outputs();
        full_m = ((16 - mq.size()) < 2);
        if (flush) begin
            mq.delete();
        end else begin
            req  = (issued && !stall) ? (dual ? 2 : 1) : 0;
            popn = (req > mq.size()) ? mq.size() : req;
            repeat (popn) void'(mq.pop_front());
            if (!full_m && we1) mq.push_back({i1, a1});
            if (!full_m && we1 && we2) mq.push_back({i2, a2});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gen(input logic we1, input logic we2, input logic issued,
                       input logic dual, input logic stall, input logic flush);
        logic [31:0] s1;
        logic [31:0] s2;
        s1 = seq;
        s2 = seq + 32'd1;
        seq = seq + 32'd2;
        step(we1, we2, 32'h2400_0000 | s1, 32'hBFC0_0000 + (s1 << 2),
                       32'h2400_0000 | s2, 32'hBFC0_0000 + (s2 << 2),
             issued, dual, stall, flush);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fetch_we1_i = 1'b0; fetch_we2_i = 1'b0; issued_i = 1'b0; issue_i = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        rst = 1'b1;
    endtask

    task automatic idle();
        gen(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        fetch_inst1_i = '0; fetch_inst2_i = '0; fetch_addr1_i = '0; fetch_addr2_i = '0;
        do_reset();

        // Reset state, idle
        repeat (3) idle();
        chk("rst_issue_en", {31'b0, issue_en_o}, 32'd0);
        chk("rst_full",     {31'b0, full_o},     32'd0);
        chk("rst_inst1",    inst1_o,             32'd0);

        // Dual push then dual issue
        step(1, 1, 32'h2401_0001, 32'hBFC0_0000, 32'h2402_0002, 32'hBFC0_0004, 0, 0, 0, 0);
        chk("t2_inst1", inst1_o,      32'h2401_0001);
        chk("t2_addr1", inst1_addr_o, 32'hBFC0_0000);
        chk("t2_inst2", inst2_o,      32'h2402_0002);
        chk("t2_addr2", inst2_addr_o, 32'hBFC0_0004);
        gen(0, 0, 1, 1, 0, 0);
        chk("t2_empty", {31'b0, issue_en_o}, 32'd0);

        // Three entries, dual pop leaves the third; dual request at count=1 pops one
        seq = 32'd100;
        gen(1, 1, 0, 0, 0, 0);
        gen(1, 0, 0, 0, 0, 0);
        gen(0, 0, 1, 1, 0, 0);
        chk("t3_addr1", inst1_addr_o, 32'hBFC0_0000 + (32'd102 << 2));
        chk("t3_v2",    {31'b0, inst2_valid_o}, 32'd0);
        gen(0, 0, 1, 1, 0, 0);
        chk("t3_empty", {31'b0, issue_en_o}, 32'd0);
        idle();

        // Full threshold
        repeat (7) gen(1, 1, 0, 0, 0, 0);
        chk("t4_full14", {31'b0, full_o}, 32'd0);
        gen(1, 0, 0, 0, 0, 0);
        chk("t4_full15", {31'b0, full_o}, 32'd1);
        gen(1, 1, 0, 0, 0, 0);
        gen(1, 1, 1, 0, 0, 0);
        chk("t4_pop1", {31'b0, full_o}, 32'd0);
        repeat (8) gen(0, 0, 1, 1, 0, 0);
        chk("t4_drained", {31'b0, issue_en_o}, 32'd0);

        // Wrap: continuous push and pop across index 15->0
        do_reset();
        for (int i = 0; i < 40; i++) gen(1, (i % 3) != 0, (i > 2), (i % 2) == 0, 0, 0);
        repeat (10) gen(0, 0, 1, 1, 0, 0);
        chk("t5_drained", {31'b0, issue_en_o}, 32'd0);

        // Flush beats push and pop; stall holds the queue
        repeat (3) gen(1, 1, 0, 0, 0, 0);
        gen(1, 1, 1, 1, 0, 1);
        chk("t6_flush", {31'b0, issue_en_o}, 32'd0);
        gen(1, 1, 0, 0, 0, 0);
        gen(0, 0, 1, 1, 1, 0);
        chk("t6_stall", {31'b0, inst2_valid_o}, 32'd1);

        // Mid-operation reset
        gen(1, 1, 0, 0, 0, 0);
        do_reset();
        idle();
        chk("t7_rst_addr1", inst1_addr_o, 32'd0);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            gen(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
